// File: rtl/kernel_mem_writer.sv
// Streams kernel weights then biases into a flat kernel memory, laying out
// each kernel as [bias, w0 .. wW-1] with pointer-incremented addresses.
module kernel_mem_writer #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH       = 32,
  parameter int N_CHANNELS       = 1,
  parameter int N_KERNELS        = 32,
  parameter int KERNEL_SIZE      = 3,
  parameter int KERNEL_BASE_ADDR = 0
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [ADDR_WIDTH-1:0] kernel_wraddress_o,
  output logic [DATA_WIDTH-1:0] kernel_wrdata_o,
  output logic                  kernel_wren_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int W  = N_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int S  = W + 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;
  localparam int NW = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;

  localparam logic [JW-1:0]         J_LAST = JW'(W - 1);
  localparam logic [NW-1:0]         N_LAST = NW'(N_KERNELS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(KERNEL_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(S);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO    = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

  state_t                  state_q, state_d;
  logic [JW-1:0]           j_q, j_d;
  logic [NW-1:0]           n_q, n_d;
  logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]   bptr_q, bptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wren_q, wren_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;

  assign accept = data_valid_i && ready_q;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    n_d     = n_q;
    wptr_d  = wptr_q;
    bptr_d  = bptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LOAD_W;
        j_d     = '0;
        n_d     = '0;
        wptr_d  = BASE + ONE;
        bptr_d  = BASE;
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      LOAD_W: if (accept) begin
        wren_d = 1'b1;
        data_d = data_i;
        addr_d = wptr_q;
        if (j_q == J_LAST) begin
          // Hop over the next kernel's bias slot.
          j_d    = '0;
          wptr_d = wptr_q + TWO;
          if (n_q == N_LAST) begin
            n_d     = '0;
            state_d = LOAD_B;
          end else begin
            n_d = n_q + NW'(1);
          end
        end else begin
          j_d    = j_q + JW'(1);
          wptr_d = wptr_q + ONE;
        end
      end
      LOAD_B: if (accept) begin
        wren_d = 1'b1;
        data_d = data_i;
        addr_d = bptr_q;
        bptr_d = bptr_q + STRIDE;
        if (n_q == N_LAST) begin
          state_d = DONE;
          ready_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      j_q     <= '0;
      n_q     <= '0;
      wptr_q  <= BASE + ONE;
      bptr_q  <= BASE;
      addr_q  <= BASE;
      data_q  <= '0;
      wren_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      n_q     <= n_d;
      wptr_q  <= wptr_d;
      bptr_q  <= bptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_ready_o       = ready_q;
  assign kernel_wraddress_o = addr_q;
  assign kernel_wrdata_o    = data_q;
  assign kernel_wren_o      = wren_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_kernel_mem_writer.sv
// Randomized stream bench for kernel_mem_writer: default geometry plus a
// 2-channel/2-kernel instance at a non-zero base, checked against a layout model.
module tb_kernel_mem_writer;
  logic        clk = 1'b0;
  logic        reset_ni;
  logic        start1, start2;
  logic [31:0] data;
  logic        valid;
  logic        ready1, wren1, busy1, done1;
  logic        ready2, wren2, busy2, done2;
  logic [15:0] addr1, addr2;
  logic [31:0] wdata1, wdata2;

  int checks = 0;
  int errors = 0;
  logic [31:0] mask;

  logic [15:0] qa1[$], qa2[$];
  logic [31:0] qd1[$], qd2[$];
  int done_cnt1, done_idx1, done_cnt2, done_idx2;
  logic done_wren1, done_wren2;

  always #5 clk = ~clk;

  kernel_mem_writer dut1 (
    .clock_i(clk), .reset_ni(reset_ni), .start_i(start1), .data_i(data),
    .data_valid_i(valid), .data_ready_o(ready1), .kernel_wraddress_o(addr1),
    .kernel_wrdata_o(wdata1), .kernel_wren_o(wren1), .busy_o(busy1), .done_o(done1)
  );

  kernel_mem_writer #(.N_CHANNELS(2), .N_KERNELS(2), .KERNEL_BASE_ADDR(16)) dut2 (
    .clock_i(clk), .reset_ni(reset_ni), .start_i(start2), .data_i(data),
    .data_valid_i(valid), .data_ready_o(ready2), .kernel_wraddress_o(addr2),
    .kernel_wrdata_o(wdata2), .kernel_wren_o(wren2), .busy_o(busy2), .done_o(done2)
  );

  // Layout model: weights kernel-major after each bias slot, then biases.
  function automatic logic [15:0] exp_addr(int i, int nk, int w, int base);
    int s = w + 1;
    if (i < nk * w) return 16'((base + (i / w) * s + 1 + (i % w)) & 16'hFFFF);
    return 16'((base + (i - nk * w) * s) & 16'hFFFF);
  endfunction

  always @(negedge clk) begin
    if (wren1) begin qa1.push_back(addr1); qd1.push_back(wdata1); end
    if (done1) begin done_cnt1++; done_idx1 = qa1.size(); done_wren1 = wren1; end
    if (wren2) begin qa2.push_back(addr2); qd2.push_back(wdata2); end
    if (done2) begin done_cnt2++; done_idx2 = qa2.size(); done_wren2 = wren2; end
  end

  task automatic clear_mon();
    qa1.delete(); qd1.delete(); qa2.delete(); qd2.delete();
    done_cnt1 = 0; done_idx1 = 0; done_cnt2 = 0; done_idx2 = 0;
    done_wren1 = 1'b0; done_wren2 = 1'b0;
    mask = $urandom;
  endtask

  task automatic run_stream(input bit sel, input int total, input int pct,
                            input bit noise, input int stop_after);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    @(negedge clk);
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    while (idx < total && idx < stop_after && cyc < 5000) begin
      valid = ($urandom_range(99) < pct);
      data  = idx ^ mask;
      start1 = (!sel && noise && (idx == 50 || idx == 51));
      rdy = sel ? ready2 : ready1;
      @(posedge clk);
      if (valid && rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    valid = 1'b0; start1 = 1'b0;
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d, required %0d", idx, total);
    end
    if (noise) begin
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; start1 = 0; start2 = 0; valid = 0; data = '0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready1); end
    if (wren1 !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", wren1); end
    if (addr1 !== 16'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr1); end
    if (wdata1 !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", wdata1); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done1); end
    if (addr2 !== 16'd16) begin errors++; $display("FAIL reset_addr2: got %0d want 16", addr2); end
    reset_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_default(input string tag);
    checks++;
    if (qa1.size() != 320) begin
      errors++; $display("FAIL %s_count: got %0d strobes want 320", tag, qa1.size());
    end
    for (int i = 0; i < qa1.size() && i < 320; i++) begin
      checks++;
      if (qa1[i] !== exp_addr(i, 32, 9, 0) || qd1[i] !== (i ^ mask)) begin
        errors++;
        $display("FAIL %s_pair[%0d]: got addr %0d data %h want addr %0d data %h",
                 tag, i, qa1[i], qd1[i], exp_addr(i, 32, 9, 0), i ^ mask);
      end
    end
    checks += 3;
    if (done_cnt1 != 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt1); end
    if (done_idx1 != 320) begin errors++; $display("FAIL %s_done_pos: got %0d want 320", tag, done_idx1); end
    if (done_wren1 !== 1'b1) begin errors++; $display("FAIL %s_done_wren: got %b want 1", tag, done_wren1); end
  endtask

  task automatic test_full_stream();
    clear_mon();
    run_stream(0, 320, 100, 0, 1 << 30);
    repeat (4) @(negedge clk);
    check_default("full");
    checks += 7;
    if (qa1[0] !== 16'd1) begin errors++; $display("FAIL spot_w0: got %0d want 1", qa1[0]); end
    if (qa1[8] !== 16'd9) begin errors++; $display("FAIL spot_w8: got %0d want 9", qa1[8]); end
    if (qa1[9] !== 16'd11) begin errors++; $display("FAIL spot_w9: got %0d want 11", qa1[9]); end
    if (qa1[287] !== 16'd319) begin errors++; $display("FAIL spot_w287: got %0d want 319", qa1[287]); end
    if (qa1[288] !== 16'd0) begin errors++; $display("FAIL spot_b0: got %0d want 0", qa1[288]); end
    if (qa1[289] !== 16'd10) begin errors++; $display("FAIL spot_b1: got %0d want 10", qa1[289]); end
    if (qa1[319] !== 16'd310) begin errors++; $display("FAIL spot_b31: got %0d want 310", qa1[319]); end
  endtask

  task automatic test_random_gaps();
    clear_mon();
    run_stream(0, 320, 40, 0, 1 << 30);
    repeat (4) @(negedge clk);
    check_default("gaps");
  endtask

  task automatic test_start_ignored();
    clear_mon();
    run_stream(0, 320, 70, 1, 1 << 30);
    repeat (6) @(negedge clk);
    check_default("start_noise");
    checks += 2;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL start_noise_busy: got %b want 0", busy1); end
    if (ready1 !== 1'b0) begin errors++; $display("FAIL start_noise_ready: got %b want 0", ready1); end
  endtask

  task automatic test_reset_midload();
    clear_mon();
    run_stream(0, 320, 100, 0, 100);
    #2 reset_ni = 1'b0;
    #1;
    checks += 6;
    if (wren1 !== 1'b0) begin errors++; $display("FAIL midrst_wren: got %b want 0", wren1); end
    if (ready1 !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", ready1); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy1); end
    if (addr1 !== 16'd0) begin errors++; $display("FAIL midrst_addr: got %0d want 0", addr1); end
    if (wdata1 !== 32'd0) begin errors++; $display("FAIL midrst_data: got %h want 0", wdata1); end
    if (qa1.size() != 100) begin errors++; $display("FAIL midrst_count: got %0d want 100", qa1.size()); end
    repeat (3) @(negedge clk);
    checks++;
    if (qa1.size() != 100) begin errors++; $display("FAIL midrst_no_strobe: got %0d want 100", qa1.size()); end
    reset_ni = 1'b1;
    clear_mon();
    run_stream(0, 320, 100, 0, 1 << 30);
    repeat (4) @(negedge clk);
    checks++;
    if (qa1[0] !== 16'd1 || qd1[0] !== mask) begin
      errors++; $display("FAIL restart_w0: got addr %0d data %h want addr 1 data %h", qa1[0], qd1[0], mask);
    end
    check_default("restart");
  endtask

  task automatic test_small_config();
    int spot_i[6] = '{0, 17, 18, 35, 36, 37};
    int spot_a[6] = '{17, 34, 36, 53, 16, 35};
    clear_mon();
    run_stream(1, 38, 60, 0, 1 << 30);
    repeat (4) @(negedge clk);
    checks++;
    if (qa2.size() != 38) begin errors++; $display("FAIL small_count: got %0d want 38", qa2.size()); end
    for (int i = 0; i < qa2.size() && i < 38; i++) begin
      checks++;
      if (qa2[i] !== exp_addr(i, 2, 18, 16) || qd2[i] !== (i ^ mask)) begin
        errors++;
        $display("FAIL small_pair[%0d]: got addr %0d data %h want addr %0d data %h",
                 i, qa2[i], qd2[i], exp_addr(i, 2, 18, 16), i ^ mask);
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (qa2[spot_i[k]] !== 16'(spot_a[k])) begin
        errors++; $display("FAIL small_spot[%0d]: got %0d want %0d", spot_i[k], qa2[spot_i[k]], spot_a[k]);
      end
    end
    checks += 2;
    if (done_cnt2 != 1 || done_idx2 != 38) begin
      errors++; $display("FAIL small_done: got count %0d pos %0d want 1 at 38", done_cnt2, done_idx2);
    end
    if (qa1.size() != 0) begin errors++; $display("FAIL small_isolation: got %0d strobes want 0", qa1.size()); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_full_stream();
    test_random_gaps();
    test_start_ignored();
    test_reset_midload();
    test_small_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kernel_mem_writer.md
KERNEL_MEM_WRITER -- requirements
Module: kernel_mem_writer

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16, kernel memory address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 The module SHALL have parameter N_CHANNELS, default 1, input channels per kernel.
REQ-004 The module SHALL have parameter N_KERNELS, default 32, number of kernels.
REQ-005 The module SHALL have parameter KERNEL_SIZE, default 3, kernel side length K.
REQ-006 The module SHALL have parameter KERNEL_BASE_ADDR, default 0, first memory word of the kernel region.
REQ-007 The module SHALL have port clock_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 The module SHALL have port reset_ni, input, 1 bit; reset is asynchronous and active-low.
REQ-009 The module SHALL have port start_i, input, 1 bit, begin a load sequence.
REQ-010 The module SHALL have port data_i, input, DATA_WIDTH bits, incoming stream word.
REQ-011 The module SHALL have port data_valid_i, input, 1 bit, data_i is valid.
REQ-012 The module SHALL have port data_ready_o, output, 1 bit, the module accepts data_i this cycle.
REQ-013 The module SHALL have port kernel_wraddress_o, output, ADDR_WIDTH bits, memory write address.
REQ-014 The module SHALL have port kernel_wrdata_o, output, DATA_WIDTH bits, memory write data.
REQ-015 The module SHALL have port kernel_wren_o, output, 1 bit, memory write strobe.
REQ-016 The module SHALL have port busy_o, output, 1 bit, a load is in progress.
REQ-017 The module SHALL have port done_o, output, 1 bit, one-cycle completion pulse.

Function
REQ-018 Definitions: S = N_CHANNELS*K*K+1 (per-kernel stride); W = N_CHANNELS*K*K (weights per kernel).
REQ-019 Memory layout per kernel n: bias at KERNEL_BASE_ADDR+n*S; weight j (0..W-1, channel-major) at KERNEL_BASE_ADDR+n*S+1+j.
REQ-020 Input stream order: all N_KERNELS*W weights (kernel-major, then channel, row, column), then N_KERNELS biases (kernel 0 first).
REQ-021 States: IDLE, LOAD_W, LOAD_B, DONE.
REQ-022 IDLE: busy_o=0, data_ready_o=0; start_i=1 -> LOAD_W next cycle, kernel and weight counters cleared.
REQ-023 start_i SHALL be ignored outside IDLE.
REQ-024 data_ready_o SHALL be 1 exactly in LOAD_W and LOAD_B; busy_o SHALL be 1 in LOAD_W, LOAD_B and DONE.
REQ-025 Accept = data_valid_i && data_ready_o; only accepted words advance counters.
REQ-026 Accept at edge t -> at t+1 kernel_wren_o=1, kernel_wrdata_o=accepted word, kernel_wraddress_o per REQ-019; 1-cycle latency.
REQ-027 kernel_wren_o SHALL be 0 in every cycle not following an accept; address/data hold their last values.
REQ-028 LOAD_W: j increments per accept; at j=W-1 j wraps to 0 and n increments; accept of (n=N_KERNELS-1, j=W-1) -> LOAD_B with n=0.
REQ-029 LOAD_B: n increments per accept; accept with n=N_KERNELS-1 -> DONE.
REQ-030 DONE lasts one cycle with done_o=1, coinciding with the final write strobe; then IDLE.
REQ-031 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; the configuration must satisfy KERNEL_BASE_ADDR+N_KERNELS*S <= 2^ADDR_WIDTH.
REQ-032 Addresses SHALL be generated by incrementing pointers (weight pointer +1, +2 across a kernel boundary; bias pointer +S), not by runtime multipliers.
REQ-033 Gaps in data_valid_i (any length) SHALL stall without skipping or duplicating writes.

Reset
REQ-034 With reset_ni=0, asynchronously: state=IDLE, all counters 0, data_ready_o=0, kernel_wren_o=0, kernel_wraddress_o=KERNEL_BASE_ADDR, kernel_wrdata_o=0, busy_o=0, done_o=0.
REQ-035 Reset mid-load SHALL abandon the sequence; no write strobe after reset assertion; the next start_i restarts from word 0.

Verification
REQ-036 Defaults, start_i pulse, stream values 0..319 with data_valid_i held 1 -> writes: word0->addr1, word8->addr9, word9->addr11, word287->addr319, word288->addr0, word289->addr10, word319->addr310; exactly 320 strobes.
REQ-037 Same stream with data_valid_i toggled pseudo-randomly -> identical address/data pairs in order; done_o is a single pulse on the cycle of the 320th strobe.
REQ-038 start_i asserted during LOAD_W and during DONE -> no effect; sequence and strobe count unchanged.
REQ-039 reset_ni pulsed low after 100 accepts -> outputs at reset values immediately; a restart rewrites word0 to addr1.
REQ-040 N_CHANNELS=2, N_KERNELS=2, KERNEL_BASE_ADDR=16 -> weights to 17..34 except 35; word18 (kernel1 elem0)->addr36; biases->16 and 35.
